// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready handshake: single-cycle basic ops, iterative multiply/divide.
// Define ALU_MULDIV_EN to build the MUL/DIV family (ops 10..17); otherwise those ops report illegal.
module alu_multicycle #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      alu_op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);

   localparam int unsigned SHW = $clog2(XLEN);

   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_SUB  = 5'd1;
   localparam logic [4:0] OP_AND  = 5'd2;
   localparam logic [4:0] OP_OR   = 5'd3;
   localparam logic [4:0] OP_XOR  = 5'd4;
   localparam logic [4:0] OP_SLL  = 5'd5;
   localparam logic [4:0] OP_SRL  = 5'd6;
   localparam logic [4:0] OP_SRA  = 5'd7;
   localparam logic [4:0] OP_SLT  = 5'd8;
   localparam logic [4:0] OP_SLTU = 5'd9;
`ifdef ALU_MULDIV_EN
   localparam logic [4:0] OP_MUL    = 5'd10;
   localparam logic [4:0] OP_MULH   = 5'd11;
   localparam logic [4:0] OP_MULHSU = 5'd12;
   localparam logic [4:0] OP_MULHU  = 5'd13;
   localparam logic [4:0] OP_DIV    = 5'd14;
   localparam logic [4:0] OP_DIVU   = 5'd15;
   localparam logic [4:0] OP_REM    = 5'd16;
   localparam logic [4:0] OP_REMU   = 5'd17;
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
`endif

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t          state_q, state_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            zero_q, zero_d;
   logic            illegal_q, illegal_d;

   logic            accept;
   logic            long_op;
   logic            basic_ill;
   logic [XLEN-1:0] basic_res;
   logic [SHW-1:0]  shamt;

   assign accept = in_valid && in_ready_q;
   assign shamt  = src_b[SHW-1:0];

   // Single-cycle results, short-circuit multiply/divide corner cases, and long-op detection
   always_comb begin
      basic_res = '0;
      basic_ill = 1'b0;
      long_op   = 1'b0;
      case (alu_op)
         OP_ADD:  basic_res = src_a + src_b;
         OP_SUB:  basic_res = src_a - src_b;
         OP_AND:  basic_res = src_a & src_b;
         OP_OR:   basic_res = src_a | src_b;
         OP_XOR:  basic_res = src_a ^ src_b;
         OP_SLL:  basic_res = src_a << shamt;
         OP_SRL:  basic_res = src_a >> shamt;
         OP_SRA:  basic_res = XLEN'($signed(src_a) >>> shamt);
         OP_SLT:  basic_res = XLEN'($signed(src_a) < $signed(src_b));
         OP_SLTU: basic_res = XLEN'(src_a < src_b);
`ifdef ALU_MULDIV_EN
         OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: long_op = 1'b1;
         OP_DIV: begin
            if (src_b == '0)                            basic_res = '1;
            else if (src_a == MOST_NEG && src_b == '1)  basic_res = src_a;
            else                                        long_op   = 1'b1;
         end
         OP_DIVU: begin
            if (src_b == '0) basic_res = '1;
            else             long_op   = 1'b1;
         end
         OP_REM: begin
            if (src_b == '0)                            basic_res = src_a;
            else if (src_a == MOST_NEG && src_b == '1)  basic_res = '0;
            else                                        long_op   = 1'b1;
         end
         OP_REMU: begin
            if (src_b == '0) basic_res = src_a;
            else             long_op   = 1'b1;
         end
`endif
         default: basic_ill = 1'b1;
      endcase
   end

`ifdef ALU_MULDIV_EN
   logic [SHW-1:0]    cnt_q;
   logic [4:0]        op_q;
   logic              neg_q, rneg_q;
   logic [2*XLEN-1:0] mcand_q, acc_q;
   logic [XLEN-1:0]   mplier_q, quo_q, rem_q, dvsr_q;

   logic              a_sgn, b_sgn;
   logic [XLEN-1:0]   abs_a, abs_b;
   logic [2*XLEN-1:0] prod_nxt, prod_fin;
   logic [XLEN:0]     rem_sh, diff;
   logic [XLEN-1:0]   rem_nxt, quo_nxt, md_res;
   logic              md_last;

   assign a_sgn = (alu_op == OP_MULH) || (alu_op == OP_MULHSU) || (alu_op == OP_DIV) || (alu_op == OP_REM);
   assign b_sgn = (alu_op == OP_MULH) || (alu_op == OP_DIV) || (alu_op == OP_REM);
   assign abs_a = (a_sgn && src_a[XLEN-1]) ? -src_a : src_a;
   assign abs_b = (b_sgn && src_b[XLEN-1]) ? -src_b : src_b;
   assign md_last = (state_q == S_BUSY) && (cnt_q == SHW'(XLEN-1));

   // One shift-add and one restoring-division step per cycle on magnitudes; sign fixed at the end
   always_comb begin
      prod_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
      rem_sh   = {rem_q, quo_q[XLEN-1]};
      diff     = rem_sh - {1'b0, dvsr_q};
      rem_nxt  = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
      quo_nxt  = {quo_q[XLEN-2:0], ~diff[XLEN]};
      prod_fin = neg_q ? -prod_nxt : prod_nxt;
      case (op_q)
         OP_MUL:                       md_res = prod_fin[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: md_res = prod_fin[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              md_res = neg_q ? -quo_nxt : quo_nxt;
         default:                      md_res = rneg_q ? -rem_nxt : rem_nxt;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         dvsr_q   <= '0;
      end else if (accept && long_op) begin
         cnt_q    <= '0;
         op_q     <= alu_op;
         neg_q    <= (a_sgn & src_a[XLEN-1]) ^ (b_sgn & src_b[XLEN-1]);
         rneg_q   <= a_sgn & src_a[XLEN-1];
         mcand_q  <= {{XLEN{1'b0}}, abs_a};
         acc_q    <= '0;
         mplier_q <= abs_b;
         quo_q    <= abs_a;
         rem_q    <= '0;
         dvsr_q   <= abs_b;
      end else if (state_q == S_BUSY) begin
         cnt_q    <= cnt_q + SHW'(1);
         acc_q    <= prod_nxt;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         rem_q    <= rem_nxt;
         quo_q    <= quo_nxt;
      end
   end
`endif

   // Control FSM next state and registered outputs
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      zero_d      = zero_q;
      illegal_d   = illegal_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (long_op) begin
                  state_d = S_BUSY;
               end else begin
                  state_d     = S_DONE;
                  out_valid_d = 1'b1;
                  result_d    = basic_res;
                  zero_d      = (basic_res == '0);
                  illegal_d   = basic_ill;
               end
            end
         end
`ifdef ALU_MULDIV_EN
         S_BUSY: begin
            if (md_last) begin
               state_d     = S_DONE;
               out_valid_d = 1'b1;
               result_d    = md_res;
               zero_d      = (md_res == '0);
               illegal_d   = 1'b0;
            end
         end
`endif
         S_DONE: begin
            if (out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      in_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b1;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         illegal_q   <= illegal_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (XLEN=32); honours ALU_MULDIV_EN like the design.
module tb_alu_multicycle;
   localparam int unsigned XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [4:0]      alu_op;
   logic [XLEN-1:0] src_a, src_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            zero;
   logic            illegal;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_multicycle #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .src_a     (src_a),
      .src_b     (src_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic on the architectural operand values
   function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic ill, output int lat);
      longint sa, sb;
`ifdef ALU_MULDIV_EN
      longint unsigned ua, ub;
      logic [63:0] p;
      ua = 64'(a);
      ub = 64'(b);
`endif
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      r   = '0;
      ill = 1'b0;
      lat = 1;
      case (op)
         5'd0: r = a + b;
         5'd1: r = a - b;
         5'd2: r = a & b;
         5'd3: r = a | b;
         5'd4: r = a ^ b;
         5'd5: r = a << b[4:0];
         5'd6: r = a >> b[4:0];
         5'd7: r = 32'($signed(a) >>> b[4:0]);
         5'd8: r = (sa < sb) ? 32'd1 : 32'd0;
         5'd9: r = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MULDIV_EN
         5'd10: begin p = 64'(sa * sb); r = p[31:0]; lat = 33; end
         5'd11: begin p = 64'(sa * sb); r = p[63:32]; lat = 33; end
         5'd12: begin p = 64'(sa * longint'(ua)); r = p[63:32]; lat = 33; end
         5'd13: begin p = ua * ub; r = p[63:32]; lat = 33; end
         5'd14: begin
            if (b == 32'd0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
            else begin r = 32'(sa / sb); lat = 33; end
         end
         5'd15: begin
            if (b == 32'd0) r = 32'hFFFF_FFFF;
            else begin r = a / b; lat = 33; end
         end
         5'd16: begin
            if (b == 32'd0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
            else begin r = 32'(sa % sb); lat = 33; end
         end
         5'd17: begin
            if (b == 32'd0) r = a;
            else begin r = a % b; lat = 33; end
         end
`endif
         default: ill = 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'd1;
         4:       return 32'($urandom_range(0, 40));
         5:       return 32'd0 - 32'($urandom_range(1, 40));
         default: return $urandom;
      endcase
   endfunction

   // Issue one request, check latency and result, optionally stall the consumer for hold cycles
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input string tag);
      logic [31:0] er;
      logic        ei;
      int          el, lat;
      model(op, a, b, er, ei, el);
      check({tag, ":ready_idle"}, 64'(in_ready), 64'd1);
      in_valid  = 1'b1;
      alu_op    = op;
      src_a     = a;
      src_b     = b;
      out_ready = (hold == 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      alu_op   = 5'($urandom);
      src_a    = $urandom;
      src_b    = $urandom;
      lat      = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, ":out_valid"}, 64'(out_valid), 64'd1);
      check({tag, ":latency"}, 64'(lat), 64'(el));
      check({tag, ":result"}, 64'(result), 64'(er));
      check({tag, ":zero"}, 64'(zero), 64'(er == 32'd0));
      check({tag, ":illegal"}, 64'(illegal), 64'(ei));
      check({tag, ":ready_done"}, 64'(in_ready), 64'd0);
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         check({tag, ":hold_valid"}, 64'(out_valid), 64'd1);
         check({tag, ":hold_result"}, 64'(result), 64'(er));
         check({tag, ":hold_ready"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check({tag, ":valid_drop"}, 64'(out_valid), 64'd0);
      check({tag, ":ready_back"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      int vcount;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      alu_op    = '0;
      src_a     = '0;
      src_b     = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset:in_ready", 64'(in_ready), 64'd0);
      check("reset:out_valid", 64'(out_valid), 64'd0);
      check("reset:result", 64'(result), 64'd0);
      check("reset:zero", 64'(zero), 64'd1);
      check("reset:illegal", 64'(illegal), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("reset:ready_after", 64'(in_ready), 64'd1);

      run_op(5'd0, 32'hFFFF_FFFF, 32'd1, 0, "add_wrap");
      run_op(5'd7, 32'h8000_0000, 32'h24, 0, "sra_mask");
      run_op(5'd8, 32'hFFFF_FFFF, 32'd1, 0, "slt");
      run_op(5'd9, 32'hFFFF_FFFF, 32'd1, 0, "sltu");
      run_op(5'd1, 32'd5, 32'd9, 0, "sub");
      run_op(5'd5, 32'h0000_00F1, 32'h3F, 0, "sll");
      run_op(5'd6, 32'hF000_0000, 32'h21, 0, "srl");
      run_op(5'd25, 32'h1234_5678, 32'h9ABC_DEF0, 0, "illegal25");
`ifdef ALU_MULDIV_EN
      run_op(5'd11, 32'h8000_0000, 32'h8000_0000, 0, "mulh");
      run_op(5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu");
      run_op(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
      run_op(5'd17, 32'd7, 32'd0, 0, "remu_zero");
      run_op(5'd14, 32'hFFFF_FFF9, 32'd2, 0, "div_neg");
      run_op(5'd16, 32'hFFFF_FFF9, 32'd2, 0, "rem_neg");
      run_op(5'd10, 32'h0001_2345, 32'h0000_6789, 5, "mul_hold");
`else
      run_op(5'd10, 32'h0001_2345, 32'h0000_6789, 0, "mul_disabled");
      run_op(5'd10, 32'h0001_2345, 32'h0000_6789, 5, "mul_hold");
`endif

      // Reset in the middle of an operation: nothing may come out afterwards
      in_valid  = 1'b1;
      alu_op    = 5'd10;
      src_a     = 32'd3;
      src_b     = 32'd4;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst:in_ready", 64'(in_ready), 64'd0);
      check("midrst:out_valid", 64'(out_valid), 64'd0);
      check("midrst:result", 64'(result), 64'd0);
      check("midrst:zero", 64'(zero), 64'd1);
      check("midrst:illegal", 64'(illegal), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("midrst:ready_after", 64'(in_ready), 64'd1);
      vcount = 0;
      repeat (40) begin
         if (out_valid) vcount++;
         @(posedge clk); #1;
      end
      check("midrst:no_output", 64'(vcount), 64'd0);

      for (int i = 0; i < 60; i++) begin
         logic [4:0]  op;
         logic [31:0] a, b;
         op = 5'($urandom_range(0, 31));
         a  = pick();
         b  = pick();
         run_op(op, a, b, (i % 10 == 3) ? 2 : 0, "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; power of two, 8..64.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  operation request valid.
REQ-005 in_ready  out  1  block can accept a request.
REQ-006 alu_op  in  5  operation code (REQ-011).
REQ-007 src_a, src_b  in  XLEN each  operands.
REQ-008 out_valid  out  1  result valid.
REQ-009 out_ready  in  1  consumer accepts result.
REQ-010 result  out  XLEN; zero  out  1  (result==0); illegal  out  1  unsupported alu_op.

Function
REQ-011 Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU; 18..31 illegal.
REQ-012 Shift amount SHALL be src_b[$clog2(XLEN)-1:0]; SLT signed, SLTU unsigned compare, result 1 or 0.
REQ-013 FSM states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 Handshake: transfer when valid&&ready high on same edge; operands and alu_op captured at the in_valid&&in_ready edge; later input changes ignored.
REQ-015 Ops 0..9, illegal ops and REQ-018/019 short-circuit cases: IDLE->DONE; out_valid SHALL rise the cycle after acceptance (latency 1).
REQ-016 MUL family: IDLE->BUSY, iterative shift-add, one bit per cycle, XLEN BUSY cycles, then DONE; out_valid rises XLEN+1 cycles after acceptance.
REQ-017 MUL returns low XLEN bits of the 2*XLEN product; MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned return high XLEN bits.
REQ-018 DIV family: restoring division, one quotient bit per cycle, same latency as REQ-016; quotient rounds toward zero, remainder takes dividend's sign.
REQ-019 Divide by zero: DIV/DIVU result all-ones, REM/REMU result src_a; signed overflow (DIV, src_a=most-negative, src_b=-1): DIV result src_a, REM result 0.
REQ-020 Illegal op: result 0, zero 1, illegal 1; otherwise illegal 0.
REQ-021 DONE: result, zero, illegal, out_valid SHALL hold stable until out_valid&&out_ready; then DONE->IDLE next edge.
REQ-022 New request accepted no earlier than the cycle after result transfer (no overlap); back-to-back basic ops therefore take 2 cycles each with out_ready held 1.
REQ-023 result, zero, illegal SHALL only change on entry to DONE.

Reset
REQ-024 rst high at a clock edge SHALL force IDLE, out_valid 0, result 0, zero 1, illegal 0, iteration counter 0, in any state including mid-BUSY; aborted operation produces no output.
REQ-025 While rst high in_ready SHALL read 0; in_ready 1 from first edge after rst falls.

Configuration
REQ-026 Macro ALU_MULDIV_EN: defined -> ops 10..17 implemented per REQ-016..019; undefined -> ops 10..17 treated as illegal (REQ-020, latency 1), no multiply/divide datapath or BUSY state synthesised.

Verification
REQ-027 ADD 0xFFFFFFFF+1 (XLEN=32), out_ready=1 -> out_valid one cycle after accept, result 0, zero 1, illegal 0.
REQ-028 SRA 0x80000000 by src_b=0x24 -> shift 4, result 0xF8000000; SLT -1,1 -> 1; SLTU -1,1 -> 0.
REQ-029 MULH 0x80000000×0x80000000 -> result 0x40000000 exactly 33 cycles after accept; MULHSU -1×0xFFFFFFFF -> 0xFFFFFFFF.
REQ-030 DIV 0x80000000/-1 -> 0x80000000 latency 1; REMU 7/0 -> 7; DIV -7/2 -> -3; REM -7/2 -> -1.
REQ-031 MUL accepted, out_ready held 0 five cycles after out_valid -> result stable, in_ready 0; rst pulsed mid-BUSY on a second MUL -> out_valid never rises, in_ready 1 next cycle.
REQ-032 Without ALU_MULDIV_EN, alu_op=10 -> illegal 1, result 0, latency 1; alu_op=25 with macro -> same.
